// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: plays a 4-step selector schedule into the output mux,
// holding each step's selector for a programmable number of ticks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped, sel forced to 00, waiting for start
// S_RUN   | prescaler and dwell counter running, sel = current step
// S_PAUSE | playback frozen, counters and outputs hold
// S_DONE  | one-cycle state after a one-shot schedule completes
module mux_sel_sequencer #(
   parameter int CLK_FREQ = 50000000,
   parameter int TICK_HZ  = 100,
   parameter int DWELL_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               loop_en,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [1:0]         cfg_sel,
   input  logic [DWELL_W-1:0] cfg_dwell,
   output logic [1:0]         sel,
   output logic [1:0]         step,
   output logic               busy,
   output logic               done
);

   localparam int PRESC = CLK_FREQ / TICK_HZ;
   localparam int PW    = $clog2(PRESC);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
   logic [DWELL_W-1:0]   dlat_q, dlat_d;
   logic [1:0]           sel_d, step_d;
   logic                 busy_d, done_d;
   logic [1:0]           tbl_sel   [4];
   logic [DWELL_W-1:0]   tbl_dwell [4];
   logic                 tick, last_tick;
   logic [DWELL_W-1:0]   dwell_end;
   logic [1:0]           next_step;

   // A latched dwell of 0 behaves like 1, so the last tick is at count 0.
   assign dwell_end = (dlat_q == '0) ? '0 : dlat_q - DWELL_W'(1);
   assign tick      = (presc_q == PW'(PRESC - 1));
   assign last_tick = tick && (dcnt_q == dwell_end);
   assign next_step = step + 2'd1;

   // Schedule table; writes land at the next edge and never touch the
   // already-latched dwell or the sel currently driven.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            tbl_sel[i]   <= 2'(i);
            tbl_dwell[i] <= DWELL_W'(100);
         end
      end else if (cfg_we) begin
         tbl_sel[cfg_addr]   <= cfg_sel;
         tbl_dwell[cfg_addr] <= cfg_dwell;
      end
   end

   // State, counters and all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         dcnt_q  <= '0;
         dlat_q  <= '0;
         sel     <= 2'd0;
         step    <= 2'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         dcnt_q  <= dcnt_d;
         dlat_q  <= dlat_d;
         sel     <= sel_d;
         step    <= step_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next-state and next-output decode; stop beats start beats pause.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      dcnt_d  = dcnt_q;
      dlat_d  = dlat_q;
      sel_d   = sel;
      step_d  = step;
      busy_d  = busy;
      done_d  = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         presc_d = '0;
         dcnt_d  = '0;
         sel_d   = 2'd0;
         step_d  = 2'd0;
         busy_d  = 1'b0;
      end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
         state_d = S_RUN;
         presc_d = '0;
         dcnt_d  = '0;
         dlat_d  = tbl_dwell[0];
         sel_d   = tbl_sel[0];
         step_d  = 2'd0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               sel_d  = 2'd0;
               busy_d = 1'b0;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            S_RUN: begin
               if (last_tick) begin
                  presc_d = '0;
                  dcnt_d  = '0;
                  if (step != 2'd3 || loop_en) begin
                     step_d = next_step;
                     sel_d  = tbl_sel[next_step];
                     dlat_d = tbl_dwell[next_step];
                  end else begin
                     state_d = S_DONE;
                     sel_d   = 2'd0;
                     step_d  = 2'd0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else if (tick) begin
                  presc_d = '0;
                  dcnt_d  = dcnt_q + DWELL_W'(1);
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               // The cycle that sees pause still counts; freezing starts next.
               if (pause && state_d == S_RUN) state_d = S_PAUSE;
            end
            S_PAUSE: begin
               if (!pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule
